// File: rtl/oa22_drv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oa22_drv_pkg : shared types and helpers for the OA22 vector driver   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package oa22_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } drv_state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // OA22 truth function: vec[0]=IN1 .. vec[3]=IN4
  function automatic logic oa22_exp(input logic [3:0] vec);
    return (vec[0] | vec[1]) & (vec[2] | vec[3]);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oa22_vec_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oa22_vec_gen : sequence index to input vector (binary or Gray order) |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module oa22_vec_gen
  import oa22_drv_pkg::*;
(
  input  logic [3:0] i_idx,
  input  logic       i_mode,
  output logic [3:0] o_vec
);

  assign o_vec = (i_mode == MODE_GRAY) ? (i_idx ^ (i_idx >> 1)) : i_idx;

endmodule
`default_nettype wire

// File: rtl/oa22_vector_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oa22_vector_driver : OA22X2 stimulus driver with activity/mismatch   |
// | statistics. Revision 1.0                                             |
// +----------------------------------------------------------------------+
module oa22_vector_driver
  import oa22_drv_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 2
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             MODE,
  input  logic [7:0]       PASSES,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             IN4,
  input  logic             Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       VEC_IDX,
  output logic [CNT_W-1:0] MISMATCH_CNT,
  output logic [CNT_W-1:0] QTOG_CNT,
  output logic [CNT_W-1:0] DRVTOG_CNT,
  output logic             ERR
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  drv_state_t       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       pass_q, pass_d;
  logic [7:0]       last_pass_q, last_pass_d;
  logic [7:0]       hold_q, hold_d;
  logic             mode_q, mode_d;
  logic [3:0]       in_q, in_d;
  logic             q_prev_q, q_prev_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] qtog_cnt_q, qtog_cnt_d;
  logic [CNT_W-1:0] drvtog_cnt_q, drvtog_cnt_d;

  logic [3:0]       vec_cur;
  logic [3:0]       vec_nxt;

  oa22_vec_gen u_gen_cur (
    .i_idx  (idx_q),
    .i_mode (mode_q),
    .o_vec  (vec_cur)
  );

  oa22_vec_gen u_gen_nxt (
    .i_idx  (idx_q + 4'd1),
    .i_mode (mode_q),
    .o_vec  (vec_nxt)
  );

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [2:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-2){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    last_pass_d  = last_pass_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    in_d         = in_q;
    q_prev_d     = q_prev_q;
    err_d        = err_q;
    mis_cnt_d    = mis_cnt_q;
    qtog_cnt_d   = qtog_cnt_q;
    drvtog_cnt_d = drvtog_cnt_q;

    case (state_q)
      IDLE: begin
        in_d = 4'b0000;
        if (START) begin
          state_d      = DRIVE;
          mode_d       = MODE;
          last_pass_d  = (PASSES == 8'd0) ? 8'd0 : PASSES - 8'd1;
          idx_d        = 4'd0;
          pass_d       = 8'd0;
          hold_d       = 8'd0;
          q_prev_d     = 1'b0;
          err_d        = 1'b0;
          mis_cnt_d    = '0;
          qtog_cnt_d   = '0;
          drvtog_cnt_d = '0;
        end
      end

      DRIVE: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          if (Q != oa22_exp(vec_cur)) begin
            mis_cnt_d = sat_add(mis_cnt_q, 3'd1);
            err_d     = 1'b1;
          end
          if (Q != q_prev_q) begin
            qtog_cnt_d = sat_add(qtog_cnt_q, 3'd1);
          end
          q_prev_d = Q;
          hold_d   = 8'd0;
          // The last vector of the last pass drops straight back to 0000
          if (idx_q == 4'd15 && pass_q == last_pass_q) begin
            state_d = FIN;
            in_d    = 4'b0000;
          end else begin
            idx_d = idx_q + 4'd1;
            in_d  = vec_nxt;
            if (idx_q == 4'd15) begin
              pass_d = pass_q + 8'd1;
            end
          end
          drvtog_cnt_d = sat_add(drvtog_cnt_q, popcount4(in_q ^ in_d));
        end
      end

      FIN: begin
        state_d = IDLE;
        in_d    = 4'b0000;
      end

      default: begin
        state_d = IDLE;
        in_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      pass_q       <= 8'd0;
      last_pass_q  <= 8'd0;
      hold_q       <= 8'd0;
      mode_q       <= MODE_BIN;
      in_q         <= 4'b0000;
      q_prev_q     <= 1'b0;
      err_q        <= 1'b0;
      mis_cnt_q    <= '0;
      qtog_cnt_q   <= '0;
      drvtog_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      last_pass_q  <= last_pass_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      in_q         <= in_d;
      q_prev_q     <= q_prev_d;
      err_q        <= err_d;
      mis_cnt_q    <= mis_cnt_d;
      qtog_cnt_q   <= qtog_cnt_d;
      drvtog_cnt_q <= drvtog_cnt_d;
    end
  end

  assign {IN4, IN3, IN2, IN1} = in_q;
  assign BUSY         = (state_q == DRIVE);
  assign DONE         = (state_q == FIN);
  assign VEC_IDX      = idx_q;
  assign MISMATCH_CNT = mis_cnt_q;
  assign QTOG_CNT     = qtog_cnt_q;
  assign DRVTOG_CNT   = drvtog_cnt_q;
  assign ERR          = err_q;

endmodule
`default_nettype wire
